// File: rtl/io_input_port.sv
`default_nettype none
// ============================================================================
//  Module   : io_input_port
//  Purpose  : Memory-mapped input peripheral. Synchronises and debounces
//             slide switches and push buttons, latches sticky press events,
//             counts presses (saturating) and raises a maskable irq level.
//  Revision : 1.0  initial release
// ============================================================================
module io_input_port #(
  parameter int NSW             = 16,
  parameter int NBTN            = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NSW-1:0]  sw_raw,
  input  logic [NBTN-1:0] btn_raw,
  input  logic            sel,
  input  logic            we,
  input  logic [2:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            irq
);

  // Switches occupy the low bits of the combined input vector, buttons the top.
  localparam int            c_nin  = NSW + NBTN;
  localparam int            c_cw   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_cw-1:0] c_last = c_cw'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_cw-1:0] c_one  = c_cw'(1);

  logic [c_nin-1:0] r_s1;
  logic [c_nin-1:0] r_s2;
  logic [c_nin-1:0] r_stable;
  logic [c_nin-1:0] w_stable_next;

  logic [NBTN-1:0]  r_evt;
  logic [NBTN-1:0]  r_mask;
  logic [15:0]      r_press_cnt;

  logic [NBTN-1:0]  w_rise;
  logic [NBTN-1:0]  w_w1c;
  logic [NBTN-1:0]  w_evt_next;
  logic [5:0]       w_npress;
  logic [15:0]      w_cnt_base;
  logic [16:0]      w_cnt_sum;
  logic [15:0]      w_cnt_next;
  logic             w_wr;
  logic             w_wr_evt;
  logic             w_wr_mask;
  logic             w_wr_cnt;
  logic             w_unused_wdata;

  // Two-flop synchroniser for every raw input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= {btn_raw, sw_raw};
      r_s2 <= r_s1;
    end
  end

  // Per-input debounce: a level is accepted once it has differed from the
  // stable value for DEBOUNCE_CYCLES consecutive cycles.
  generate
    for (genvar gi = 0; gi < c_nin; gi++) begin : g_deb
      logic [c_cw-1:0] r_cnt;
      logic            w_diff;
      logic            w_done;

      assign w_diff            = r_s2[gi] ^ r_stable[gi];
      assign w_done            = w_diff && (r_cnt == c_last);
      assign w_stable_next[gi] = w_done ? r_s2[gi] : r_stable[gi];

      // Qualification counter; restarts on any glitch back or on acceptance.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt <= '0;
        end else if (!w_diff || w_done) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_one;
        end
      end
    end
  endgenerate

  // Debounced level register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= '0;
    end else begin
      r_stable <= w_stable_next;
    end
  end

  assign w_wr      = sel & we;
  assign w_wr_evt  = w_wr && (addr == 3'd2);
  assign w_wr_mask = w_wr && (addr == 3'd3);
  assign w_wr_cnt  = w_wr && (addr == 3'd4);
  assign w_unused_wdata = ^wdata;

  // Press detection on the edge the button level is accepted; a new press
  // overrides a W1C of the same bit, and a counter clear happens before the add.
  always_comb begin
    w_rise   = w_stable_next[c_nin-1:NSW] & ~r_stable[c_nin-1:NSW];
    w_w1c    = w_wr_evt ? wdata[NBTN-1:0] : '0;
    w_evt_next = (r_evt & ~w_w1c) | w_rise;
    w_npress = '0;
    for (int i = 0; i < NBTN; i++) begin
      w_npress = w_npress + {5'b0, w_rise[i]};
    end
    w_cnt_base = w_wr_cnt ? 16'h0 : r_press_cnt;
    w_cnt_sum  = {1'b0, w_cnt_base} + {11'b0, w_npress};
    w_cnt_next = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
  end

  // Event flags, irq mask and press counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_evt       <= '0;
      r_mask      <= '0;
      r_press_cnt <= '0;
    end else begin
      r_evt       <= w_evt_next;
      r_press_cnt <= w_cnt_next;
      if (w_wr_mask) begin
        r_mask <= wdata[NBTN-1:0];
      end
    end
  end

  assign irq = |(r_evt & r_mask);

  // Read mux; unselected or unmapped reads return zero.
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        3'd0:    rdata[NSW-1:0]  = r_stable[NSW-1:0];
        3'd1:    rdata[NBTN-1:0] = r_stable[c_nin-1:NSW];
        3'd2:    rdata[NBTN-1:0] = r_evt;
        3'd3:    rdata[NBTN-1:0] = r_mask;
        3'd4:    rdata[15:0]     = r_press_cnt;
        default: rdata = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_input_port.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_io_input_port
//  Purpose  : Self-checking bench for io_input_port with a window-based
//             debounce reference model and register-map model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_io_input_port;

  localparam int NSW  = 16;
  localparam int NBTN = 4;
  localparam int D    = 4;
  localparam int NIN  = NSW + NBTN;
  localparam int H    = D + 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] sw_raw;
  logic [3:0]  btn_raw;
  logic        sel;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  always #5 clk = ~clk;

  io_input_port #(.NSW(NSW), .NBTN(NBTN), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw), .btn_raw(btn_raw),
    .sel(sel), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: hist[k] = raw vector sampled k edges ago. A level is
  // accepted when the D samples that reached the debouncer all disagree with it.
  bit [NIN-1:0] hist [H];
  bit [NIN-1:0] m_stable;
  bit [3:0]     m_evt;
  bit [3:0]     m_mask;
  int           m_cnt;

  function automatic void model_reset();
    for (int k = 0; k < H; k++) hist[k] = '0;
    m_stable = '0;
    m_evt    = '0;
    m_mask   = '0;
    m_cnt    = 0;
  endfunction

  function automatic void model_edge(bit w, bit [2:0] a, bit [31:0] d, bit [NIN-1:0] raw);
    bit [NIN-1:0] nxt;
    bit [3:0]     rise;
    bit           moved;
    for (int k = H - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = raw;
    nxt = m_stable;
    for (int b = 0; b < NIN; b++) begin
      moved = 1'b1;
      for (int k = 2; k < H; k++) if (hist[k][b] == m_stable[b]) moved = 1'b0;
      if (moved) nxt[b] = ~m_stable[b];
    end
    rise = nxt[NIN-1:NSW] & ~m_stable[NIN-1:NSW];
    if (w && a == 3'd2) m_evt = m_evt & ~d[3:0];
    if (w && a == 3'd3) m_mask = d[3:0];
    if (w && a == 3'd4) m_cnt = 0;
    m_evt = m_evt | rise;
    m_cnt = m_cnt + $countones(rise);
    if (m_cnt > 65535) m_cnt = 65535;
    m_stable = nxt;
  endfunction

  function automatic logic [31:0] model_read(bit s, int a);
    logic [31:0] r;
    r = '0;
    if (s) begin
      case (a)
        0: r[15:0] = m_stable[15:0];
        1: r[3:0]  = m_stable[19:16];
        2: r[3:0]  = m_evt;
        3: r[3:0]  = m_mask;
        4: r[15:0] = 16'(m_cnt);
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // Full register-map and irq check, completes within the low clock phase.
  task automatic sweep();
    chk("irq", {31'b0, irq}, {31'b0, |(m_evt & m_mask)});
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a);
      sel  = 1'b1;
      #0.2;
      chk($sformatf("rd%0d", a), rdata, model_read(1'b1, a));
      sel = 1'b0;
      #0.2;
      chk($sformatf("nosel%0d", a), rdata, 32'h0);
    end
  endtask

  // One clock: optional bus write, model update at the edge, then checks.
  task automatic cyc(input bit w, input bit [2:0] a, input logic [31:0] d);
    sel   = w;
    we    = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    model_edge(w, a, d, {btn_raw, sw_raw});
    @(negedge clk);
    we  = 1'b0;
    sel = 1'b0;
    sweep();
  endtask

  task automatic rd_chk(input string tag, input bit [2:0] a, input logic [31:0] exp);
    sel  = 1'b1;
    addr = a;
    #0.1;
    chk(tag, rdata, exp);
    sel = 1'b0;
  endtask

  initial begin
    #1ms;
    n_bad++;
    $display("FAIL watchdog: got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    int b;
    bit wr;
    reset_n = 1'b0;
    sw_raw  = 16'hA5A5;
    btn_raw = 4'h0;
    sel     = 1'b0;
    we      = 1'b0;
    addr    = 3'd0;
    wdata   = 32'h0;
    model_reset();

    // Reset state.
    @(negedge clk);
    #1;
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rd_chk("rst_sw", 3'd0, 32'h0);
    rd_chk("rst_cnt", 3'd4, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Switch latency after reset release: 0 through edge 5, A5A5 from edge 6.
    for (int e = 1; e <= 8; e++) begin
      cyc(1'b0, 3'd0, 32'h0);
      rd_chk($sformatf("sw_edge%0d", e), 3'd0, (e >= 6) ? 32'h0000A5A5 : 32'h0);
    end

    // Bouncing button 1: 1,0,1 then held.
    btn_raw = 4'b0010;
    cyc(1'b0, 3'd0, 32'h0);
    btn_raw = 4'b0000;
    cyc(1'b0, 3'd0, 32'h0);
    btn_raw = 4'b0010;
    for (int e = 3; e <= 7; e++) begin
      cyc(1'b0, 3'd0, 32'h0);
      rd_chk($sformatf("bounce_evt%0d", e), 3'd2, 32'h0);
    end
    cyc(1'b0, 3'd0, 32'h0);
    rd_chk("bounce_evt", 3'd2, 32'h2);
    rd_chk("bounce_cnt", 3'd4, 32'h1);

    // irq masking and W1C.
    cyc(1'b1, 3'd3, 32'h2);
    chk("irq_on", {31'b0, irq}, 32'h1);
    cyc(1'b1, 3'd2, 32'h1);
    chk("irq_keep", {31'b0, irq}, 32'h1);
    rd_chk("w1c_other", 3'd2, 32'h2);
    cyc(1'b1, 3'd2, 32'h2);
    chk("irq_off", {31'b0, irq}, 32'h0);

    // W1C on the same edge a new press is accepted: set wins.
    btn_raw = 4'b0000;
    repeat (10) cyc(1'b0, 3'd0, 32'h0);
    btn_raw = 4'b0010;
    repeat (5) cyc(1'b0, 3'd0, 32'h0);
    rd_chk("evt_pre", 3'd2, 32'h0);
    cyc(1'b1, 3'd2, 32'h2);
    rd_chk("w1c_vs_set", 3'd2, 32'h2);

    // Counter saturation: preload near the top, then three simultaneous presses.
    force dut.r_press_cnt = 16'hFFFE;
    #0.2;
    release dut.r_press_cnt;
    m_cnt = 65534;
    rd_chk("preload", 3'd4, 32'h0000FFFE);
    btn_raw = 4'b1111;
    repeat (6) cyc(1'b0, 3'd0, 32'h0);
    rd_chk("sat", 3'd4, 32'h0000FFFF);
    rd_chk("sat_evt", 3'd2, 32'hF);
    cyc(1'b1, 3'd4, 32'h0);
    rd_chk("ct_clr", 3'd4, 32'h0);

    // Randomised slow-changing inputs with random bus writes.
    repeat (400) begin
      if ($urandom_range(0, 5) == 0) begin
        b = $urandom_range(0, NIN - 1);
        if (b < NSW) sw_raw[b] = ~sw_raw[b];
        else         btn_raw[b-NSW] = ~btn_raw[b-NSW];
      end
      wr = ($urandom_range(0, 3) == 0);
      cyc(wr, 3'($urandom_range(0, 7)), $urandom());
    end

    // Async reset mid-debounce with irq active.
    cyc(1'b1, 3'd3, 32'hF);
    btn_raw = 4'b0000;
    sw_raw  = 16'h1234;
    repeat (8) cyc(1'b0, 3'd0, 32'h0);
    btn_raw = 4'b1111;
    repeat (8) cyc(1'b0, 3'd0, 32'h0);
    chk("pre_rst_irq", {31'b0, irq}, 32'h1);
    sw_raw = 16'hEDCB;
    repeat (4) cyc(1'b0, 3'd0, 32'h0);
    reset_n = 1'b0;
    #0.2;
    chk("rst_mid_irq", {31'b0, irq}, 32'h0);
    for (int a = 0; a < 8; a++) rd_chk($sformatf("rst_mid_rd%0d", a), 3'(a), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) cyc(1'b0, 3'd0, 32'h0);
    rd_chk("held_evt_e5", 3'd2, 32'h0);
    cyc(1'b0, 3'd0, 32'h0);
    rd_chk("held_evt_e6", 3'd2, 32'hF);
    rd_chk("held_sw_e6", 3'd0, 32'h0000EDCB);
    rd_chk("held_cnt_e6", 3'd4, 32'h4);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
